// File: rtl/prescaled_counter.sv
// prescaled_counter: up/down counter advanced by a 2^N prescaler tick.
// Count modes are wrap, saturate and bounce. TICK and TC are registered and
// land on the same edge as the count update they belong to.
module prescaled_counter #(
  parameter int WIDTH = 8,
  parameter int N     = 22
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIR,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] Q,
  output logic             TICK,
  output logic             TC
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic             tick_int;
  logic [WIDTH-1:0] q_q, q_d;
  logic             bd_q, bd_d;
  logic             tick_q, tick_d;
  logic             tc_q, tc_d;

  generate
    if (N == 0) begin : g_no_pre
      // Without a prescaler, every enabled cycle is a tick.
      assign tick_int = EN;
    end else begin : g_pre
      logic [N-1:0] p_q, p_d;

      // Prescaler next value: LOAD restarts it; otherwise it advances while enabled.
      always_comb begin
        p_d = p_q;
        if (LOAD)    p_d = '0;
        else if (EN) p_d = p_q + N'(1);
      end

      // Prescaler register.
      always_ff @(posedge CLK) begin
        if (RST) p_q <= '0;
        else     p_q <= p_d;
      end

      assign tick_int = EN && (p_q == '1);
    end
  endgenerate

  // Count next-state. A LOAD in the same cycle as a tick swallows that tick.
  always_comb begin
    q_d    = q_q;
    bd_d   = bd_q;
    tc_d   = 1'b0;
    tick_d = tick_int && !LOAD;
    if (LOAD) begin
      q_d  = DIN;
      bd_d = DIR;
    end else if (tick_int) begin
      case (MODE)
        2'b01: begin
          if (DIR) begin
            if (q_q != MAX) q_d = q_q + ONE;
            tc_d = (q_q == MAX - ONE);
          end else begin
            if (q_q != '0) q_d = q_q - ONE;
            tc_d = (q_q == ONE);
          end
        end
        2'b10: begin
          if (bd_q) begin
            if (q_q == MAX) begin
              q_d  = MAX - ONE;
              bd_d = 1'b0;
              tc_d = 1'b1;
            end else begin
              q_d = q_q + ONE;
            end
          end else begin
            if (q_q == '0) begin
              q_d  = ONE;
              bd_d = 1'b1;
              tc_d = 1'b1;
            end else begin
              q_d = q_q - ONE;
            end
          end
        end
        default: begin
          if (DIR) begin
            q_d  = q_q + ONE;
            tc_d = (q_q == MAX);
          end else begin
            q_d  = q_q - ONE;
            tc_d = (q_q == '0);
          end
        end
      endcase
    end
  end

  // Count, bounce direction and pulse registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q    <= '0;
      bd_q   <= 1'b1;
      tick_q <= 1'b0;
      tc_q   <= 1'b0;
    end else begin
      q_q    <= q_d;
      bd_q   <= bd_d;
      tick_q <= tick_d;
      tc_q   <= tc_d;
    end
  end

  assign Q    = q_q;
  assign TICK = tick_q;
  assign TC   = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Bench for prescaled_counter: two WIDTH=4 instances (N=2 and N=0) share the
// same stimulus. A behavioural model predicts each edge; expected values are
// queued at drive time and popped when the outputs are sampled.
module tb_prescaled_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b0, EN = 1'b0, LOAD = 1'b0, DIR = 1'b0;
  logic [3:0] DIN = '0;
  logic [1:0] MODE = '0;
  logic [3:0] q_a, q_b;
  logic       tick_a, tick_b, tc_a, tc_b;

  int checks = 0;
  int errors = 0;
  int tick_cnt_a, tc_cnt_a;

  typedef struct packed {
    int p;
    int q;
    int bd;
    int tick;
    int tc;
  } mstate_t;

  typedef struct packed {
    mstate_t a;
    mstate_t b;
  } exp_t;

  mstate_t ma, mb;
  exp_t    sb_q[$];

  prescaled_counter #(.WIDTH(4), .N(2)) dut_a (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DIN(DIN), .DIR(DIR),
    .MODE(MODE), .Q(q_a), .TICK(tick_a), .TC(tc_a)
  );

  prescaled_counter #(.WIDTH(4), .N(0)) dut_b (
    .CLK(CLK), .RST(RST), .EN(EN), .LOAD(LOAD), .DIN(DIN), .DIR(DIR),
    .MODE(MODE), .Q(q_b), .TICK(tick_b), .TC(tc_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic mstate_t mnext(mstate_t s, int n, bit rst, bit en, bit ld,
                                    int din, bit dir, int mode);
    mstate_t r;
    int period;
    bit tk;
    r = s;
    r.tick = 0;
    r.tc = 0;
    period = 1 << n;
    if (rst) begin
      r.p = 0; r.q = 0; r.bd = 1;
      return r;
    end
    tk = en && (s.p == period - 1);
    if (ld) begin
      r.p = 0; r.q = din; r.bd = dir;
      return r;
    end
    if (en) r.p = (s.p + 1) % period;
    if (tk) begin
      r.tick = 1;
      if (mode == 1) begin
        if (dir) begin
          if (s.q < 15) r.q = s.q + 1;
          r.tc = (s.q < 15) && (r.q == 15);
        end else begin
          if (s.q > 0) r.q = s.q - 1;
          r.tc = (s.q > 0) && (r.q == 0);
        end
      end else if (mode == 2) begin
        if (s.bd == 1 && s.q == 15) begin
          r.q = 14; r.bd = 0; r.tc = 1;
        end else if (s.bd == 0 && s.q == 0) begin
          r.q = 1; r.bd = 1; r.tc = 1;
        end else begin
          r.q = (s.bd == 1) ? s.q + 1 : s.q - 1;
        end
      end else begin
        r.q = dir ? (s.q + 1) % 16 : (s.q + 15) % 16;
        r.tc = dir ? (s.q == 15) : (s.q == 0);
      end
    end
    return r;
  endfunction

  task automatic step(input bit rst, input bit en, input bit ld, input int din,
                      input bit dir, input int mode);
    exp_t e;
    @(negedge CLK);
    RST  = rst;
    EN   = en;
    LOAD = ld;
    DIN  = din[3:0];
    DIR  = dir;
    MODE = mode[1:0];
    ma = mnext(ma, 2, rst, en, ld, din, dir, mode);
    mb = mnext(mb, 0, rst, en, ld, din, dir, mode);
    e.a = ma;
    e.b = mb;
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk("a_q", int'(q_a), e.a.q);
    chk("a_tick", int'(tick_a), e.a.tick);
    chk("a_tc", int'(tc_a), e.a.tc);
    chk("b_q", int'(q_b), e.b.q);
    chk("b_tick", int'(tick_b), e.b.tick);
    chk("b_tc", int'(tc_b), e.b.tc);
    tick_cnt_a += int'(tick_a);
    tc_cnt_a   += int'(tc_a);
  endtask

  initial begin
    ma = '0;
    mb = '0;

    // Reset.
    step(1, 0, 0, 0, 1, 0);
    step(1, 1, 1, 7, 1, 0);
    chk("rst_q", int'(q_a), 0);
    chk("rst_tick", int'(tick_a), 0);

    // Wrap up, N=2: tick every 4 cycles, Q 0..15,0, TC only on 15->0.
    tick_cnt_a = 0; tc_cnt_a = 0;
    for (int i = 0; i < 64; i++) begin
      step(0, 1, 0, 0, 1, 0);
      if (i == 3) begin
        chk("wrap_first_tick", int'(tick_a), 1);
        chk("wrap_first_q", int'(q_a), 1);
      end
      if (i == 59) chk("wrap_q15", int'(q_a), 15);
    end
    chk("wrap_ticks", tick_cnt_a, 16);
    chk("wrap_tcs", tc_cnt_a, 1);
    chk("wrap_end_q", int'(q_a), 0);

    // Saturate down from 2: Q 2,1,0,0,0 with a single TC.
    step(0, 1, 1, 2, 0, 1);
    chk("sat_load_q", int'(q_a), 2);
    tick_cnt_a = 0; tc_cnt_a = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 0, 1);
      if (i == 7) chk("sat_tc_on_zero", int'(tc_a), 1);
    end
    chk("sat_end_q", int'(q_a), 0);
    chk("sat_tcs", tc_cnt_a, 1);
    chk("sat_ticks", tick_cnt_a, 5);

    // EN freeze: three enabled cycles, five disabled, then tick on first enabled cycle.
    step(0, 1, 1, 5, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    tick_cnt_a = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0);
    chk("freeze_q", int'(q_a), 5);
    chk("freeze_ticks", tick_cnt_a, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("resume_tick", int'(tick_a), 1);
    chk("resume_q", int'(q_a), 6);

    // RST beats LOAD; LOAD on a tick cycle swallows the tick.
    step(1, 1, 1, 9, 1, 0);
    chk("rst_over_load", int'(q_a), 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    step(0, 1, 1, 9, 1, 0);
    chk("load_on_tick_q", int'(q_a), 9);
    chk("load_on_tick_tc", int'(tc_a), 0);
    tick_cnt_a = 0;
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0);
    chk("load_no_early_tick", tick_cnt_a, 0);
    step(0, 1, 0, 0, 1, 0);
    chk("load_next_tick", int'(tick_a), 1);
    chk("load_next_q", int'(q_a), 10);

    // Bounce on N=0 instance: load 13 up, then 14,15,14(TC),13 ... 0,1(TC).
    step(0, 1, 1, 13, 1, 2);
    chk("bnc_load", int'(q_b), 13);
    step(0, 1, 0, 0, 0, 2);
    chk("bnc_14", int'(q_b), 14);
    step(0, 1, 0, 0, 0, 2);
    chk("bnc_15", int'(q_b), 15);
    step(0, 1, 0, 0, 0, 2);
    chk("bnc_rev_q", int'(q_b), 14);
    chk("bnc_rev_tc", int'(tc_b), 1);
    step(0, 1, 0, 0, 1, 2);
    chk("bnc_13", int'(q_b), 13);
    for (int i = 0; i < 13; i++) step(0, 1, 0, 0, 1, 2);
    chk("bnc_zero", int'(q_b), 0);
    step(0, 1, 0, 0, 1, 2);
    chk("bnc_up_q", int'(q_b), 1);
    chk("bnc_up_tc", int'(tc_b), 1);

    // Mixed random traffic, all checked against the model.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 19) == 0), int'($urandom_range(0, 15)),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prescaled_counter.md
PRESCALED_COUNTER -- requirements
Module: prescaled_counter

Interface
- REQ-001 SHALL have parameter WIDTH, default 8: counter width in bits, legal range 2..32.
- REQ-002 SHALL have parameter N, default 22: prescaler width in bits, legal range 0..32; one tick every 2^N enabled cycles.
- REQ-003 SHALL have port CLK, input, 1: sole clock; all state updates on the rising edge.
- REQ-004 SHALL have port RST, input, 1: synchronous, active-high reset.
- REQ-005 SHALL have port EN, input, 1: prescaler and counter advance enable.
- REQ-006 SHALL have port LOAD, input, 1: synchronous load strobe.
- REQ-007 SHALL have port DIN, input, WIDTH: load value.
- REQ-008 SHALL have port DIR, input, 1: count direction, 1 = up, 0 = down.
- REQ-009 SHALL have port MODE, input, 2: 00 wrap, 01 saturate, 10 bounce, 11 treated as 00.
- REQ-010 SHALL have port Q, output, WIDTH: registered count, LED-drivable.
- REQ-011 SHALL have port TICK, output, 1: registered one-cycle prescaler tick.
- REQ-012 SHALL have port TC, output, 1: registered one-cycle terminal-count pulse.

Function
- REQ-013 SHALL clock everything from the single clock CLK; reset SHALL be synchronous and active-high on RST.
- REQ-014 Prescaler SHALL be an N-bit counter P, incremented by 1 each cycle EN=1 and held when EN=0.
- REQ-015 Internal tick SHALL be asserted when EN=1 and P = 2^N-1, with P wrapping to 0 in that same cycle.
- REQ-016 When N=0, the internal tick SHALL be EN itself.
- REQ-017 TICK SHALL be the internal tick registered: high exactly one cycle, one cycle after the cycle in which P wraps.
- REQ-018 Per cycle, priority SHALL be RST > LOAD > tick > hold.
- REQ-019 On LOAD:
  - Q <= DIN, P <= 0, bounce direction BD <= DIR, TC <= 0.
  - Any tick in the same cycle SHALL be discarded.
- REQ-020 Effective direction SHALL be DIR in wrap and saturate modes, and BD in bounce mode.
- REQ-021 In wrap mode, a tick SHALL step Q by ±1 modulo 2^WIDTH.
  - TC SHALL pulse on the MAX->0 (up) and 0->MAX (down) transitions.
  - MAX = 2^WIDTH-1.
- REQ-022 In saturate mode, a tick SHALL step Q toward the bound and hold at MAX (up) or 0 (down).
  - TC SHALL pulse only on the tick that makes Q equal the bound.
  - Ticks at the bound SHALL leave Q unchanged and SHALL NOT pulse TC.
- REQ-023 In bounce mode:
  - A tick with BD=up and Q=MAX SHALL set Q <= MAX-1, BD <= down, and pulse TC.
  - A tick with BD=down and Q=0 SHALL set Q <= 1, BD <= up, and pulse TC.
  - Otherwise Q SHALL step per BD.
- REQ-024 BD SHALL change only by LOAD, by bounce reversal, or by reset; it SHALL be updated by neither DIR nor MODE changes otherwise.
- REQ-025 Q and TC SHALL update in the same edge as the tick that caused them, so TC and TICK are coincident.
- REQ-026 MODE or DIR changes SHALL take effect at the next tick with no extra latency; P SHALL NOT be cleared by them.
- REQ-027 With EN=0, P, Q and BD SHALL hold, and TICK = TC = 0 from the next cycle.
- REQ-028 Arithmetic SHALL be unsigned WIDTH-bit; no output SHALL exceed WIDTH bits.

Reset
- REQ-029 With RST=1 at a rising edge, next values SHALL be:
  - P = 0, Q = 0, BD = up, TICK = 0, TC = 0.
  - This SHALL override LOAD and EN in that cycle.
- REQ-030 Reset asserted mid-count SHALL discard prescaler progress; the first tick after release SHALL come 2^N enabled cycles later.
- REQ-031 Outputs SHALL be defined from the first edge with RST=1; no initial-value dependence SHALL be required.

Verification
- REQ-032 WIDTH=4, N=2, MODE=00, DIR=1, EN=1 after reset:
  - Required: TICK every 4 cycles; Q steps 0,1..15,0.
  - Required: TC high only with the 15->0 step.
- REQ-033 WIDTH=4, N=2, MODE=01, DIR=0, LOAD DIN=2:
  - Required: Q 2,1,0,0,0.
  - Required: TC exactly once, on the 1->0 tick.
- REQ-034 WIDTH=4, N=0, MODE=10, LOAD DIN=13 with DIR=1:
  - Required: Q 14,15,14,13...
  - Required: TC on the 15->14 tick; later TC on the 0->1 tick.
- REQ-035 WIDTH=4, N=2, EN toggled off for 5 cycles after P=2:
  - Required: Q, P frozen.
  - Required: tick arrives 1 enabled cycle after EN returns.
- REQ-036 LOAD and RST coincident, and LOAD coincident with tick:
  - Required: RST wins (Q=0).
  - Required: LOAD value appears with no increment, TC=0, and next tick 2^N cycles later.
